// File: rtl/xcvr_reconfig_arbiter_pkg.sv
// Shared types and constants for the transceiver reconfiguration arbiter.
package xcvr_reconfig_arbiter_pkg;

    localparam int          MAX_REQ      = 4;
    localparam int          PTR_W        = 2;
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RDWAIT = 2'd2,
        HOLD   = 2'd3
    } state_e;

    // Round-robin pointer for the requester following the one just granted.
    function automatic logic [PTR_W-1:0] rr_next_ptr(input logic [MAX_REQ-1:0] oh,
                                                     input int num);
        logic [PTR_W-1:0] nxt;
        nxt = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) nxt = (i + 1 >= num) ? '0 : PTR_W'(i + 1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/xcvr_reconfig_arbiter_rr_arbiter.sv
// Round-robin selector: first pending requester at or after the pointer, one-hot.
module xcvr_reconfig_arbiter_rr_arbiter
    import xcvr_reconfig_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2
)(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o
);

    logic found;
    int   pos;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        pos   = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            pos = int'(ptr_i) + off;
            if (pos >= NUM_REQ) pos = pos - NUM_REQ;
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!found && pos == j && req_i[j]) begin
                    gnt_o[j] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/xcvr_reconfig_arbiter.sv
// Arbitrates several Avalon-style requesters onto one reconfiguration slave,
// with optional grant locking for read-modify-write and a read-response timeout.
module xcvr_reconfig_arbiter
    import xcvr_reconfig_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 255
)(
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req_read,
    input  logic [NUM_REQ-1:0]     req_write,
    input  logic [NUM_REQ-1:0]     req_lock,
    input  logic [32*NUM_REQ-1:0]  req_address,
    input  logic [32*NUM_REQ-1:0]  req_wdata,
    input  logic [4*NUM_REQ-1:0]   req_be,
    output logic [NUM_REQ-1:0]     req_waitrequest,
    output logic [31:0]            req_readdata,
    output logic [NUM_REQ-1:0]     req_readdatavalid,
    output logic                   master_wen,
    output logic                   master_oen,
    output logic [31:0]            master_address,
    output logic [31:0]            master_wdata,
    output logic [3:0]             master_be,
    input  logic [31:0]            master_rdata,
    input  logic                   readdatavalid_in,
    input  logic                   waitrequest_in,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   timeout_err
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic                 is_write_q, is_write_d;
    logic                 lock_q, lock_d;
    logic [31:0]          addr_q, addr_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [3:0]           be_q, be_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [31:0]          rdata_q, rdata_d;
    logic [NUM_REQ-1:0]   rdv_q, rdv_d;
    logic                 terr_q, terr_d;

    logic [NUM_REQ-1:0]   arb_gnt;
    logic [NUM_REQ-1:0]   sel_oh;
    logic [31:0]          sel_addr, sel_wdata;
    logic [3:0]           sel_be;
    logic                 sel_write, own_req, own_lock, load;

    xcvr_reconfig_arbiter_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
        .req_i (req_read | req_write),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt)
    );

    // In HOLD the owner re-issues without arbitration, so fields come from the current grant.
    assign sel_oh    = (state_q == HOLD) ? grant_q : arb_gnt;
    assign sel_write = |(req_write & sel_oh);
    assign own_req   = |((req_read | req_write) & grant_q);
    assign own_lock  = |(req_lock & grant_q);

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_be    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel_oh[i]) begin
                sel_addr  = req_address[32*i +: 32];
                sel_wdata = req_wdata[32*i +: 32];
                sel_be    = req_be[4*i +: 4];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        is_write_d = is_write_q;
        lock_d     = lock_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        rdv_d      = '0;
        terr_d     = terr_q;
        load       = 1'b0;

        case (state_q)
            IDLE: begin
                if (|arb_gnt) begin
                    state_d = ISSUE;
                    grant_d = arb_gnt;
                    ptr_d   = rr_next_ptr(MAX_REQ'(arb_gnt), NUM_REQ);
                    load    = 1'b1;
                end
            end
            ISSUE: begin
                if (!waitrequest_in) begin
                    lock_d = own_lock;
                    if (!is_write_q) begin
                        state_d = RDWAIT;
                        cnt_d   = '0;
                    end else if (own_lock) begin
                        state_d = HOLD;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end
            end
            RDWAIT: begin
                if (readdatavalid_in) begin
                    rdata_d = master_rdata;
                    rdv_d   = grant_q;
                    if (lock_q) begin
                        state_d = HOLD;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    // Slave never answered: complete with a poison word and drop any lock.
                    rdata_d = TIMEOUT_DATA;
                    rdv_d   = grant_q;
                    terr_d  = 1'b1;
                    lock_d  = 1'b0;
                    state_d = IDLE;
                    grant_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (own_req) begin
                    state_d = ISSUE;
                    load    = 1'b1;
                end else if (!own_lock) begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase

        // Read+write together is treated as a write.
        if (load) begin
            is_write_d = sel_write;
            addr_d     = sel_addr;
            wdata_d    = sel_wdata;
            be_d       = sel_be;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            ptr_q      <= '0;
            is_write_q <= 1'b0;
            lock_q     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            cnt_q      <= '0;
            rdata_q    <= '0;
            rdv_q      <= '0;
            terr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            is_write_q <= is_write_d;
            lock_q     <= lock_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            rdv_q      <= rdv_d;
            terr_q     <= terr_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_waitrequest[i] = !((state_q == ISSUE) && grant_q[i] && !waitrequest_in);
        end
    end

    assign master_wen        = !((state_q == ISSUE) && is_write_q);
    assign master_oen        = !((state_q == ISSUE) && !is_write_q);
    assign master_address    = addr_q;
    assign master_wdata      = wdata_q;
    assign master_be         = be_q;
    assign req_readdata      = rdata_q;
    assign req_readdatavalid = rdv_q;
    assign grant             = grant_q;
    assign timeout_err       = terr_q;

endmodule

// File: tb/tb_xcvr_reconfig_arbiter.sv
// Directed bench for xcvr_reconfig_arbiter with two requesters.
module tb_xcvr_reconfig_arbiter;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [1:0]  req_read, req_write, req_lock;
    logic [31:0] a0, a1, w0, w1;
    logic [3:0]  b0, b1;
    logic [63:0] req_address, req_wdata;
    logic [7:0]  req_be;
    logic [1:0]  req_waitrequest;
    logic [31:0] req_readdata;
    logic [1:0]  req_readdatavalid;
    logic        master_wen, master_oen;
    logic [31:0] master_address, master_wdata;
    logic [3:0]  master_be;
    logic [31:0] master_rdata;
    logic        readdatavalid_in, waitrequest_in;
    logic [1:0]  grant;
    logic        timeout_err;

    int total = 0;
    int bad   = 0;

    assign req_address = {a1, a0};
    assign req_wdata   = {w1, w0};
    assign req_be      = {b1, b0};

    always #5 clock = ~clock;

    xcvr_reconfig_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(255)) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .req_read          (req_read),
        .req_write         (req_write),
        .req_lock          (req_lock),
        .req_address       (req_address),
        .req_wdata         (req_wdata),
        .req_be            (req_be),
        .req_waitrequest   (req_waitrequest),
        .req_readdata      (req_readdata),
        .req_readdatavalid (req_readdatavalid),
        .master_wen        (master_wen),
        .master_oen        (master_oen),
        .master_address    (master_address),
        .master_wdata      (master_wdata),
        .master_be         (master_be),
        .master_rdata      (master_rdata),
        .readdatavalid_in  (readdatavalid_in),
        .waitrequest_in    (waitrequest_in),
        .grant             (grant),
        .timeout_err       (timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_grant"}, 32'(grant), 32'h0);
        chk({tag, "_wen"},   32'(master_wen), 32'h1);
        chk({tag, "_oen"},   32'(master_oen), 32'h1);
        chk({tag, "_addr"},  master_address, 32'h0);
        chk({tag, "_wdata"}, master_wdata, 32'h0);
        chk({tag, "_be"},    32'(master_be), 32'h0);
        chk({tag, "_wreq"},  32'(req_waitrequest), 32'h3);
        chk({tag, "_rdv"},   32'(req_readdatavalid), 32'h0);
        chk({tag, "_rdata"}, req_readdata, 32'h0);
        chk({tag, "_terr"},  32'(timeout_err), 32'h0);
    endtask

    // Advance to the next falling edge; inputs change here, outputs are checked #1 later.
    task automatic step();
        @(negedge clock);
    endtask

    initial begin
        reset_n = 1'b0;
        req_read = '0; req_write = '0; req_lock = '0;
        a0 = '0; a1 = '0; w0 = '0; w1 = '0; b0 = '0; b1 = '0;
        master_rdata = '0; readdatavalid_in = 1'b0; waitrequest_in = 1'b1;

        // Reset state
        step(); step();
        #1 chk_reset("rst");

        // Write with three stall cycles
        step();
        reset_n = 1'b1;
        req_write[0] = 1'b1; a0 = 32'h10; w0 = 32'h5A; b0 = 4'hF;
        for (int k = 0; k < 3; k++) begin
            step();
            #1;
            chk("wr_wen_stall", 32'(master_wen), 32'h0);
            chk("wr_oen_stall", 32'(master_oen), 32'h1);
            chk("wr_addr_stall", master_address, 32'h10);
            chk("wr_data_stall", master_wdata, 32'h5A);
            chk("wr_be_stall", 32'(master_be), 32'hF);
            chk("wr_wreq_stall", 32'(req_waitrequest), 32'h3);
            chk("wr_grant_stall", 32'(grant), 32'h1);
        end
        step();
        waitrequest_in = 1'b0;
        #1;
        chk("wr_wen_accept", 32'(master_wen), 32'h0);
        chk("wr_wreq_accept", 32'(req_waitrequest), 32'h2);
        step();
        req_write[0] = 1'b0; waitrequest_in = 1'b1;
        #1;
        chk("wr_wen_done", 32'(master_wen), 32'h1);
        chk("wr_wreq_done", 32'(req_waitrequest), 32'h3);
        chk("wr_grant_done", 32'(grant), 32'h0);

        // Reset so the round-robin pointer is back at requester 0
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        #1 chk("rr_rst_grant", 32'(grant), 32'h0);

        // Simultaneous reads: req0 first, then req1, slave latency 2
        req_read = 2'b11; a0 = 32'h100; a1 = 32'h200; waitrequest_in = 1'b0;
        step();
        #1;
        chk("rd0_grant", 32'(grant), 32'h1);
        chk("rd0_oen", 32'(master_oen), 32'h0);
        chk("rd0_wen", 32'(master_wen), 32'h1);
        chk("rd0_addr", master_address, 32'h100);
        chk("rd0_wreq", 32'(req_waitrequest), 32'h2);
        step();
        req_read[0] = 1'b0;
        #1;
        chk("rd0_oen_wait", 32'(master_oen), 32'h1);
        chk("rd0_wreq_wait", 32'(req_waitrequest), 32'h3);
        step();
        readdatavalid_in = 1'b1; master_rdata = 32'hAAAA0001;
        #1 chk("rd0_rdv_early", 32'(req_readdatavalid), 32'h0);
        step();
        readdatavalid_in = 1'b0;
        #1;
        chk("rd0_rdv", 32'(req_readdatavalid), 32'h1);
        chk("rd0_rdata", req_readdata, 32'hAAAA0001);
        chk("rd0_grant_idle", 32'(grant), 32'h0);
        step();
        #1;
        chk("rd0_rdv_pulse", 32'(req_readdatavalid), 32'h0);
        chk("rd1_grant", 32'(grant), 32'h2);
        chk("rd1_addr", master_address, 32'h200);
        chk("rd1_oen", 32'(master_oen), 32'h0);
        chk("rd1_wreq", 32'(req_waitrequest), 32'h1);
        step();
        req_read[1] = 1'b0;
        step();
        readdatavalid_in = 1'b1; master_rdata = 32'hBBBB0002;
        step();
        readdatavalid_in = 1'b0;
        #1;
        chk("rd1_rdv", 32'(req_readdatavalid), 32'h2);
        chk("rd1_rdata", req_readdata, 32'hBBBB0002);

        // Stray readdatavalid_in while idle
        step();
        readdatavalid_in = 1'b1; master_rdata = 32'h0BAD0BAD;
        step();
        readdatavalid_in = 1'b0;
        #1;
        chk("stray_rdv", 32'(req_readdatavalid), 32'h0);
        chk("stray_rdata", req_readdata, 32'hBBBB0002);

        // Locked read-modify-write by req1 while req0 waits
        req_read[1] = 1'b1; req_lock[1] = 1'b1; a1 = 32'h300;
        step();
        req_write[0] = 1'b1; a0 = 32'h400; w0 = 32'h11;
        #1;
        chk("rmw_rd_grant", 32'(grant), 32'h2);
        chk("rmw_rd_oen", 32'(master_oen), 32'h0);
        chk("rmw_rd_wreq", 32'(req_waitrequest), 32'h1);
        step();
        req_read[1] = 1'b0;
        step();
        readdatavalid_in = 1'b1; master_rdata = 32'h000000F0;
        step();
        readdatavalid_in = 1'b0;
        req_write[1] = 1'b1; w1 = 32'hF1;
        #1;
        chk("rmw_rd_rdv", 32'(req_readdatavalid), 32'h2);
        chk("rmw_rd_rdata", req_readdata, 32'h000000F0);
        chk("rmw_hold_grant", 32'(grant), 32'h2);
        chk("rmw_hold_wen", 32'(master_wen), 32'h1);
        chk("rmw_hold_wreq", 32'(req_waitrequest), 32'h3);
        step();
        #1;
        chk("rmw_wr_grant", 32'(grant), 32'h2);
        chk("rmw_wr_wen", 32'(master_wen), 32'h0);
        chk("rmw_wr_addr", master_address, 32'h300);
        chk("rmw_wr_data", master_wdata, 32'hF1);
        chk("rmw_wr_wreq", 32'(req_waitrequest), 32'h1);
        step();
        req_write[1] = 1'b0;
        #1;
        chk("rmw_hold2_grant", 32'(grant), 32'h2);
        chk("rmw_hold2_wen", 32'(master_wen), 32'h1);
        step();
        #1 chk("rmw_hold3_grant", 32'(grant), 32'h2);
        req_lock[1] = 1'b0;
        step();
        #1 chk("rmw_release_grant", 32'(grant), 32'h0);
        step();
        #1;
        chk("rmw_req0_grant", 32'(grant), 32'h1);
        chk("rmw_req0_wen", 32'(master_wen), 32'h0);
        chk("rmw_req0_addr", master_address, 32'h400);
        chk("rmw_req0_data", master_wdata, 32'h11);
        step();
        req_write[0] = 1'b0;
        #1 chk("rmw_req0_done", 32'(grant), 32'h0);

        // Read that never returns data
        step();
        req_read[0] = 1'b1; a0 = 32'h500;
        step();
        #1 chk("to_grant", 32'(grant), 32'h1);
        step();
        req_read[0] = 1'b0;
        repeat (254) step();
        #1;
        chk("to_rdv_early", 32'(req_readdatavalid), 32'h0);
        chk("to_terr_early", 32'(timeout_err), 32'h0);
        step();
        #1;
        chk("to_rdv", 32'(req_readdatavalid), 32'h1);
        chk("to_rdata", req_readdata, 32'hDEADBEEF);
        chk("to_terr", 32'(timeout_err), 32'h1);
        chk("to_grant_idle", 32'(grant), 32'h0);
        step();
        #1;
        chk("to_rdv_pulse", 32'(req_readdatavalid), 32'h0);
        chk("to_terr_sticky", 32'(timeout_err), 32'h1);

        // Reset while waiting for read data
        step();
        req_read[1] = 1'b1; a1 = 32'h600;
        step();
        #1 chk("rstrd_grant", 32'(grant), 32'h2);
        step();
        req_read[1] = 1'b0;
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        readdatavalid_in = 1'b1; master_rdata = 32'h12345678;
        #1 chk_reset("rstrd");
        step();
        readdatavalid_in = 1'b0;
        #1;
        chk("rstrd_late_rdv", 32'(req_readdatavalid), 32'h0);
        chk("rstrd_late_rdata", req_readdata, 32'h0);
        step();
        #1 chk("rstrd_late_rdv2", 32'(req_readdatavalid), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/xcvr_reconfig_arbiter.md
XCVR_RECONFIG_ARBITER -- requirements
Module: xcvr_reconfig_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of requesters (legal 2..4).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum cycles from read acceptance to readdatavalid.
REQ-003 SHALL have clock  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have reset_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have req_read / req_write / req_lock  input  NUM_REQ each  per-requester read, write, and hold-grant strobes.
REQ-006 SHALL have req_address / req_wdata  input  32*NUM_REQ each  per-requester packed address and write data.
REQ-007 SHALL have req_be  input  4*NUM_REQ  per-requester byteenable.
REQ-008 SHALL have req_waitrequest  output  NUM_REQ  per-requester stall; low only in the accept cycle.
REQ-009 SHALL have req_readdata  output  32  shared read data; req_readdatavalid  output  NUM_REQ  one-hot valid.
REQ-010 SHALL have master_wen / master_oen  output  1  active-low write/read to the reconfig slave.
REQ-011 SHALL have master_address / master_wdata  output  32; master_be  output  4.
REQ-012 SHALL have master_rdata  input  32; readdatavalid_in  input  1; waitrequest_in  input  1.
REQ-013 SHALL have grant  output  NUM_REQ  one-hot current owner; timeout_err  output  1  sticky error flag.

Function
REQ-014 SHALL implement FSM IDLE, ISSUE, RDWAIT, HOLD.
REQ-015 IDLE: requester pending = req_read|req_write; SHALL select by round-robin starting at index after last grant; next cycle enter ISSUE with that grant registered.
REQ-016 ISSUE: SHALL drive granted requester's address/wdata/be; master_wen low iff its req_write, else master_oen low; both never low together.
REQ-017 If requester asserts read and write together, SHALL treat as write only.
REQ-018 ISSUE: while waitrequest_in high, SHALL hold master outputs stable; first cycle waitrequest_in low is acceptance; req_waitrequest of owner low in that same cycle only.
REQ-019 After accepted write: HOLD if req_lock of owner was high at acceptance, else IDLE.
REQ-020 After accepted read: RDWAIT; start timeout counter at 0.
REQ-021 RDWAIT: on readdatavalid_in, SHALL register master_rdata to req_readdata and pulse owner's req_readdatavalid one cycle later (read latency = slave latency + 1); then HOLD if lock else IDLE.
REQ-022 RDWAIT: if counter reaches TIMEOUT_CYCLES with no readdatavalid_in, SHALL return 32'hDEADBEEF with readdatavalid pulse, set timeout_err, go to IDLE (lock dropped).
REQ-023 readdatavalid_in outside RDWAIT SHALL be ignored.
REQ-024 HOLD: grant kept; owner's next read/write → ISSUE without arbitration; owner req_lock low and no request → IDLE; others stay stalled.
REQ-025 Round-robin pointer SHALL update only on leaving IDLE; a requester deasserting before grant SHALL simply lose its turn.
REQ-026 master_wen/master_oen SHALL be high in IDLE, RDWAIT, HOLD.
REQ-027 timeout_err SHALL clear only on reset.

Reset
REQ-028 On reset_n low at clock edge: state IDLE, grant 0, RR pointer to requester 0, master_wen/oen 1, master_address/wdata 0, master_be 0, req_waitrequest all 1, req_readdatavalid 0, req_readdata 0, counter 0, timeout_err 0.
REQ-029 Reset mid-transaction SHALL abort without completing the response; no pulse to owner.

Structure
REQ-030 Shared package SHALL hold state enum, TIMEOUT_DATA constant 32'hDEADBEEF, and MAX_REQ=4.
REQ-031 One sub-module rr_arbiter (NUM_REQ request vector + pointer → one-hot grant) SHALL be instantiated; the rest is flat.

Verification
REQ-032 Req0 write addr 0x10 data 0x5A, waitrequest_in high 3 cycles → master_wen low 4 cycles, fields stable, req_waitrequest[0] low in 4th cycle only.
REQ-033 Req0 and req1 reading simultaneously, pointer at 0 → req0 served first, then req1; slave latency 2 → each readdatavalid pulse 3 cycles after acceptance, correct data.
REQ-034 Req1 locked read-modify-write while req0 requesting → req1 read and write back-to-back, req0 granted only after req1 drops lock.
REQ-035 Read with readdatavalid_in never returned → after 255 cycles req_readdata 0xDEADBEEF, pulse, timeout_err 1 until reset.
REQ-036 reset_n low during RDWAIT → next cycle all outputs at REQ-028 values, late readdatavalid_in ignored.
